// File: rtl/fft_frame_receiver.sv
// fft_frame_receiver
//   Avalon-ST sink for the FFT core's source stream. It checks packet
//   framing, captures one N-bin frame of complex results, computes
//   re^2+im^2 for each bin serially (one bin per cycle), and publishes the
//   whole frame in one edge together with a one-cycle frame_valid strobe.
//
// Ports
//   clk, reset_n        : system clock, asynchronous active-low reset
//   src_valid/src_ready : Avalon-ST handshake (ready is registered)
//   src_sop/src_eop     : packet framing
//   src_error           : FFT error flags; any nonzero beat spoils the frame
//   src_data            : [DW-1 -: 14] real, next 14 bits imag, rest ignored
//   power               : N x PW squared magnitudes, bin 0 = power[0]
//   frame_valid         : one-cycle strobe when power takes a new frame
//   frame_count         : published frames, wraps
//   drop_count          : discarded frames, saturates
module fft_frame_receiver #(
  parameter int N  = 8,
  parameter int DW = 33,
  parameter int PW = 28
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic                  src_sop,
  input  logic                  src_eop,
  input  logic [1:0]            src_error,
  input  logic [DW-1:0]         src_data,
  output logic [N-1:0][PW-1:0]  power,
  output logic                  frame_valid,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RECV, CALC, PUBLISH} state_t;

  state_t                state_reg;
  logic [IW-1:0]         idx_reg;
  logic [IW-1:0]         calc_idx_reg;
  logic                  err_reg;
  logic [N-1:0][PW-1:0]  shadow_reg;

  // Raw sample buffer; written only while receiving, read only in CALC.
  logic signed [13:0]    re_mem [N];
  logic signed [13:0]    im_mem [N];

  logic                  beat;
  logic signed [13:0]    beat_re;
  logic signed [13:0]    beat_im;
  logic                  beat_err;
  logic [IW-1:0]         wr_idx;

  assign beat     = src_valid && src_ready;
  assign beat_re  = src_data[DW-1 -: 14];
  assign beat_im  = src_data[DW-15 -: 14];
  assign beat_err = |src_error;
  // A start-of-packet beat always lands in bin 0, whatever state we are in.
  assign wr_idx   = (state_reg == IDLE || src_sop) ? '0 : idx_reg;

  always_ff @(posedge clk) begin
    if (beat) begin
      re_mem[wr_idx] <= beat_re;
      im_mem[wr_idx] <= beat_im;
    end
  end

  // Squared magnitude of the bin currently selected by calc_idx_reg.
  logic signed [27:0] re_ext, im_ext, re_sq, im_sq;
  logic [PW-1:0]      mag;

  always_comb begin
    re_ext = 28'(re_mem[calc_idx_reg]);
    im_ext = 28'(im_mem[calc_idx_reg]);
    re_sq  = re_ext * re_ext;
    im_sq  = im_ext * im_ext;
    mag    = PW'($unsigned(re_sq) + $unsigned(im_sq));
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      src_ready    <= 1'b0;
      idx_reg      <= '0;
      calc_idx_reg <= '0;
      err_reg      <= 1'b0;
      shadow_reg   <= '0;
      power        <= '0;
      frame_valid  <= 1'b0;
      frame_count  <= '0;
      drop_count   <= '0;
    end else begin
      frame_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          src_ready <= 1'b1;
          if (beat && src_sop) begin
            if (src_eop) begin
              // A one-beat packet can never fill a frame.
              drop_count <= sat_inc(drop_count);
            end else begin
              idx_reg   <= IW'(1);
              err_reg   <= beat_err;
              state_reg <= RECV;
            end
          end
        end

        RECV: begin
          src_ready <= 1'b1;
          if (beat) begin
            if (src_sop) begin
              // Restart: this beat becomes bin 0 of a fresh frame.
              drop_count <= sat_inc(drop_count);
              idx_reg    <= IW'(1);
              err_reg    <= beat_err;
              if (src_eop) state_reg <= IDLE;
            end else if (idx_reg == LAST) begin
              state_reg <= IDLE;
              if (src_eop && !(err_reg || beat_err)) begin
                state_reg    <= CALC;
                src_ready    <= 1'b0;
                calc_idx_reg <= '0;
              end else begin
                drop_count <= sat_inc(drop_count);
              end
            end else if (src_eop) begin
              drop_count <= sat_inc(drop_count);
              state_reg  <= IDLE;
            end else begin
              idx_reg <= idx_reg + IW'(1);
              err_reg <= err_reg || beat_err;
            end
          end
        end

        CALC: begin
          src_ready                <= 1'b0;
          shadow_reg[calc_idx_reg] <= mag;
          if (calc_idx_reg == LAST) begin
            state_reg <= PUBLISH;
          end else begin
            calc_idx_reg <= calc_idx_reg + IW'(1);
          end
        end

        PUBLISH: begin
          // The whole frame becomes visible on this single edge.
          power       <= shadow_reg;
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
          src_ready   <= 1'b1;
          state_reg   <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          src_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
